// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared types and digit limits for the stopwatch control core.
//   sw_state_t   : control FSM state encoding
//   bcd_t        : one BCD digit
//   *_MAX        : terminal value of each MM:SS digit
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t UNITS_MAX    = 4'd9;
  localparam bcd_t MIN_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit
// One BCD digit counter that counts 0..MAX and rolls over.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance the digit by one this cycle
//   clr        : synchronous clear to 0 (wins over inc)
//   digit      : current digit value
//   carry      : inc while at MAX, i.e. the next digit must advance
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = UNITS_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output bcd_t digit,
  output logic carry
);

  bcd_t digit_q, digit_d;
  logic at_max;

  assign at_max = (digit_q == MAX);

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = at_max ? '0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc & at_max;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Control and timekeeping core: button edge detect, IDLE/RUN/STOP/LAP FSM,
// one-second prescaler, MM:SS BCD counter and lap-hold register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_ss     : start/stop button (level; rising edge is the event)
//   btn_lap    : lap button
//   btn_clr    : clear button
//   running    : high in RUN or LAP
//   lap_hold   : high in LAP (display frozen)
//   sec_tick   : one-cycle pulse in the cycle before each increment
//   disp_bcd   : {m1,m0,s1,s0} for the display (held value in LAP)
//   live_bcd   : live counter value
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_ss,
  input  logic        btn_lap,
  input  logic        btn_clr,
  output logic        running,
  output logic        lap_hold,
  output logic        sec_tick,
  output logic [15:0] disp_bcd,
  output logic [15:0] live_bcd
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  sw_state_t     state_q;
  logic          running_q, lap_hold_q;
  logic          ss_q, lap_q, clr_q;
  logic          ev_ss, ev_lap, ev_clr;
  logic [PW-1:0] pre_q, pre_d;
  logic          counting, wrap, do_clear, do_capture;
  logic [15:0]   hold_q;
  bcd_t          s0, s1, m0, m1;
  logic          c_s0, c_s1, c_m0, m1_carry_unused;

  // Edge detect with priority folded in: a lower-priority event is masked
  // whenever a higher-priority one occurs in the same cycle.
  assign ev_ss  = btn_ss  & ~ss_q;
  assign ev_lap = btn_lap & ~lap_q & ~ev_ss;
  assign ev_clr = btn_clr & ~clr_q & ~ev_ss & ~ev_lap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q  <= 1'b0;
      lap_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      ss_q  <= btn_ss;
      lap_q <= btn_lap;
      clr_q <= btn_clr;
    end
  end

  assign counting   = (state_q == RUN) || (state_q == LAP);
  assign wrap       = counting && (pre_q == PRE_LAST);
  assign do_clear   = (state_q == STOP) && ev_clr;
  assign do_capture = (state_q == RUN) && ev_lap;

  // STOP falls through to the hold branch so a resume finishes the
  // partial second instead of starting a fresh one.
  always_comb begin
    pre_d = pre_q;
    if ((state_q == IDLE) || do_clear) begin
      pre_d = '0;
    end else if (counting) begin
      pre_d = wrap ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // Control FSM; running/lap_hold are registered alongside the state so
  // they always describe the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ev_ss) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (ev_ss) begin
            state_q   <= STOP;
            running_q <= 1'b0;
          end else if (ev_lap) begin
            state_q    <= LAP;
            lap_hold_q <= 1'b1;
          end
        end
        LAP: begin
          if (ev_ss) begin
            state_q    <= STOP;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
          end else if (ev_lap) begin
            state_q    <= RUN;
            lap_hold_q <= 1'b0;
          end
        end
        STOP: begin
          if (ev_ss) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else if (ev_clr) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          running_q  <= 1'b0;
          lap_hold_q <= 1'b0;
        end
      endcase
    end
  end

  // Captures the pre-increment value if a second boundary lands on the
  // same edge as the lap press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (do_clear) begin
      hold_q <= '0;
    end else if (do_capture) begin
      hold_q <= live_bcd;
    end
  end

  bcd_digit #(.MAX(UNITS_MAX)) u_s0 (
    .clk(clk), .rst_n(rst_n), .inc(wrap), .clr(do_clear),
    .digit(s0), .carry(c_s0)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_s1 (
    .clk(clk), .rst_n(rst_n), .inc(c_s0), .clr(do_clear),
    .digit(s1), .carry(c_s1)
  );

  bcd_digit #(.MAX(UNITS_MAX)) u_m0 (
    .clk(clk), .rst_n(rst_n), .inc(c_s1), .clr(do_clear),
    .digit(m0), .carry(c_m0)
  );

  // 59:59 rolls over silently, so the top carry goes nowhere.
  bcd_digit #(.MAX(MIN_TENS_MAX)) u_m1 (
    .clk(clk), .rst_n(rst_n), .inc(c_m0), .clr(do_clear),
    .digit(m1), .carry(m1_carry_unused)
  );

  assign live_bcd = {m1, m0, s1, s0};
  assign disp_bcd = lap_hold_q ? hold_q : live_bcd;
  assign running  = running_q;
  assign lap_hold = lap_hold_q;
  assign sec_tick = wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_ss, btn_lap, btn_clr;
  logic        running, lap_hold, sec_tick;
  logic [15:0] disp_bcd, live_bcd;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .running(running), .lap_hold(lap_hold), .sec_tick(sec_tick),
    .disp_bcd(disp_bcd), .live_bcd(live_bcd)
  );

  always #5 clk = ~clk;

  // Cycle index: value k holds from rising edge k to rising edge k+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [15:0] live;
    logic [15:0] disp;
    logic        run;
    logic        lh;
    logic        tick;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input int at, input logic [15:0] live, input logic [15:0] disp,
                      input logic run, input logic lh, input logic tick, input string name);
    exp_t e;
    e.at = at; e.live = live; e.disp = disp;
    e.run = run; e.lh = lh; e.tick = tick; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs depend only on DUT registers, so sampling on the
  // falling edge is race-free with respect to stimulus.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (e.at < cyc) begin
          errors++;
          $display("FAIL %s: sample cycle %0d missed (now %0d)", e.name, e.at, cyc);
        end else if (live_bcd !== e.live || disp_bcd !== e.disp || running !== e.run ||
                     lap_hold !== e.lh || sec_tick !== e.tick) begin
          errors++;
          $display("FAIL %s @%0d: got live=%h disp=%h run=%b lh=%b tick=%b, want live=%h disp=%h run=%b lh=%b tick=%b",
                   e.name, cyc, live_bcd, disp_bcd, running, lap_hold, sec_tick,
                   e.live, e.disp, e.run, e.lh, e.tick);
        end
      end
    end
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: run did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive buttons for exactly one cycle starting at the current falling edge.
  task automatic press(input logic ss, input logic lap, input logic clr);
    btn_ss = ss; btn_lap = lap; btn_clr = clr;
    @(negedge clk);
    btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
  endtask

  initial begin
    int n, s, c, r, s2, h;
    rst_n = 1'b0;
    btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;

    @(negedge clk);
    n = cyc;
    push(n + 1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "reset_a");
    push(n + 2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "reset_b");
    goto(n + 3);
    rst_n = 1'b1;
    @(negedge clk);

    // Start, first second, second/minute carry, hour rollover
    s = cyc + 1;
    push(s,         16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "ss_running");
    push(s + 3,     16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, "first_tick");
    push(s + 4,     16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, "first_second");
    push(s + 40,    16'h0010, 16'h0010, 1'b1, 1'b0, 1'b0, "sec_tens_carry");
    push(s + 236,   16'h0059, 16'h0059, 1'b1, 1'b0, 1'b0, "at_00_59");
    push(s + 239,   16'h0059, 16'h0059, 1'b1, 1'b0, 1'b1, "tick_00_59");
    push(s + 240,   16'h0100, 16'h0100, 1'b1, 1'b0, 1'b0, "minute_carry");
    push(s + 14396, 16'h5959, 16'h5959, 1'b1, 1'b0, 1'b0, "at_59_59");
    push(s + 14399, 16'h5959, 16'h5959, 1'b1, 1'b0, 1'b1, "tick_59_59");
    push(s + 14400, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "hour_wrap");
    press(1'b1, 1'b0, 1'b0);

    // Pause two cycles into a second, resume, partial second completes
    c = s + 14401;
    goto(c);
    push(c + 1,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "stop");
    push(c + 21, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "stop_holds");
    press(1'b1, 1'b0, 1'b0);
    r = c + 21;
    goto(r);
    push(r + 1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "resume");
    push(r + 2, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, "resume_tick");
    push(r + 3, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, "resume_partial");
    press(1'b1, 1'b0, 1'b0);

    // Clear rules and ss/lap priority
    goto(r + 4);
    push(r + 5, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, "clr_in_run");
    press(1'b0, 1'b0, 1'b1);
    goto(r + 8);
    push(r + 9, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, "ss_lap_prio");
    press(1'b1, 1'b1, 1'b0);
    goto(r + 11);
    push(r + 12, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, "lap_in_stop");
    press(1'b0, 1'b1, 1'b0);
    goto(r + 13);
    push(r + 14, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "clr_in_stop");
    press(1'b0, 1'b0, 1'b1);
    goto(r + 15);
    push(r + 16, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "clr_in_idle");
    press(1'b0, 1'b0, 1'b1);
    goto(r + 17);
    push(r + 18, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "lap_in_idle");
    press(1'b0, 1'b1, 1'b0);

    // Restart after clear, lap behaviour
    goto(r + 19);
    s2 = r + 20;
    push(s2 + 3, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, "restart_tick");
    push(s2 + 4, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, "restart_second");
    press(1'b1, 1'b0, 1'b0);
    goto(s2 + 29);
    push(s2 + 30, 16'h0007, 16'h0007, 1'b1, 1'b1, 1'b0, "lap_enter");
    push(s2 + 40, 16'h0010, 16'h0007, 1'b1, 1'b1, 1'b0, "lap_frozen");
    press(1'b0, 1'b1, 1'b0);
    goto(s2 + 41);
    push(s2 + 42, 16'h0010, 16'h0010, 1'b1, 1'b0, 1'b0, "lap_release");
    press(1'b0, 1'b1, 1'b0);
    goto(s2 + 43);
    push(s2 + 44, 16'h0011, 16'h0010, 1'b1, 1'b1, 1'b0, "lap_same_edge");
    press(1'b0, 1'b1, 1'b0);
    goto(s2 + 45);
    push(s2 + 46, 16'h0011, 16'h0011, 1'b0, 1'b0, 1'b0, "ss_in_lap");
    press(1'b1, 1'b0, 1'b0);

    // ss held for ten cycles toggles once
    h = s2 + 47;
    goto(h);
    push(h + 10, 16'h0013, 16'h0013, 1'b1, 1'b0, 1'b1, "level_hold_single");
    push(h + 11, 16'h0014, 16'h0014, 1'b1, 1'b0, 1'b0, "level_hold_after");
    btn_ss = 1'b1;
    repeat (10) @(negedge clk);
    btn_ss = 1'b0;

    // Stop on the wrap cycle: increment lands, prescaler restarts from 0
    goto(h + 14);
    push(h + 15, 16'h0015, 16'h0015, 1'b0, 1'b0, 1'b0, "ss_on_wrap");
    press(1'b1, 1'b0, 1'b0);
    goto(h + 20);
    push(h + 24, 16'h0015, 16'h0015, 1'b1, 1'b0, 1'b1, "resume_zero_tick");
    push(h + 25, 16'h0016, 16'h0016, 1'b1, 1'b0, 1'b0, "resume_zero_inc");
    press(1'b1, 1'b0, 1'b0);

    // Reset while running
    goto(h + 26);
    push(h + 27, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "reset_mid_run");
    #1 rst_n = 1'b0;
    goto(h + 28);
    push(h + 29, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "after_reset");
    rst_n = 1'b1;
    goto(h + 31);

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never sampled", e.name, e.at);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
